mdb_bus_arbiter: RTL and testbench
==================================

# mdb_bus_arbiter

Round-robin arbiter and data latch for the 4-bit multi-drop bus. Several nodes request the shared bus. The block grants exactly one node at a time and captures that node's nibble into a held bus register. The register output drives the binary-to-hex seven-segment decoder stage directly downstream, so the display always shows the last transferred nibble.

## Interface
Parameters:
- `NUM_NODES`, 4: number of requesting nodes (2..8).
- `DATA_W`, 4: nibble width; must match the decoder input.
- `HOLD_CYCLES`, 3: cycles the grant is held after the transfer. A value of 0 skips the hold phase.

Ports:
- `Clk`  in  1: single clock; all state changes on the rising edge.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `Req`  in  NUM_NODES: per-node request level.
- `NodeData`  in  NUM_NODES*DATA_W: node i's nibble sits at `[i*DATA_W +: DATA_W]`.
- `Grant`  out  NUM_NODES: registered, one-hot or zero.
- `Owner`  out  clog2(NUM_NODES): index of the current or most recent owner.
- `BusData`  out  DATA_W: registered captured nibble; connects to the decoder binary input.
- `BusValid`  out  1: one-cycle pulse when `BusData` updates.

## Operation
- States: IDLE, GRANT, XFER, HOLD.
- **IDLE**
  - If any `Req` bit is set, pick the winner by round-robin, starting the search at `(Ptr+1) mod NUM_NODES`.
  - Register `Grant`/`Owner` for the winner and go to GRANT.
- **GRANT** (one cycle): the owner drives `NodeData`.
  - If `Req[Owner]` is still 1, go to XFER.
  - Otherwise abort: clear `Grant`, go to IDLE, leave `BusData` unchanged, leave `Ptr` unchanged.
- **XFER** (one cycle):
  - `BusData <= NodeData[Owner]`, `BusValid <= 1`, `Ptr <= Owner`.
  - Go to HOLD, or to IDLE when `HOLD_CYCLES==0`.
- **HOLD**
  - A down-counter loaded with `HOLD_CYCLES` counts down; `Grant` stays asserted.
  - At 0, clear `Grant` and go to IDLE.
  - `Req` changes during HOLD are ignored.
- Arbitration
  - After a completed transfer, the last owner has the lowest priority.
  - A node that keeps `Req` high re-competes from IDLE.
  - With a single requester, that node wins every round.
- `BusData` holds its value indefinitely between transfers. The display must not blank.
- `Req` is a level signal. Each completed GRANT→XFER counts as one transfer.
- Reset values (reset asserted asynchronously, released synchronously by design of the upstream reset synchroniser):
  - State = IDLE.
  - `Grant`=0, `Owner`=0, `BusData`=0, `BusValid`=0.
  - `Ptr`=NUM_NODES-1, so node 0 has first priority.
  - Hold counter = 0.
  - Reset mid-transfer drops the grant immediately. No partial capture.

## Timing
- Request to grant: `Req` high before edge k gives `Grant` visible after edge k.
- Capture: `BusData`/`BusValid` are visible after edge k+2.
- `NodeData` must be stable during the GRANT and XFER cycles.
- `Grant` deasserts after edge k+2+HOLD_CYCLES.
- Minimum transfer spacing is 3+HOLD_CYCLES cycles.
- `BusValid` is high for exactly one cycle per transfer.
- Decoder output follows `BusData` combinationally in the same cycle.

## Configuration
- `MDB_PARITY_EN`, defined:
  - Adds input `NodePar` [NUM_NODES] (even parity per nibble) and output `ParErr` (1-cycle pulse).
  - In XFER, if parity mismatches: `BusData` is not updated, `BusValid` stays 0, `ParErr`=1, `Ptr` still advances.
- `MDB_PARITY_EN`, undefined: the ports are absent and every XFER captures.

## Structure
- Shared package/header `mdb_pkg`:
  - State encoding constants (IDLE=0, GRANT=1, XFER=2, HOLD=3).
  - Default `NUM_NODES`/`DATA_W`.
  - A clog2 helper.
- Sub-module `mdb_rr_picker`: combinational round-robin selector.
  - Inputs: `Req`, `Ptr`.
  - Outputs: winner index and an any-request flag.
- The FSM, hold counter and data register stay in the top module.

## Test plan
- **Reset**: assert `Rst_n`=0 mid-HOLD → `Grant`=0, `BusData`=0, state IDLE on the same cycle, no clock edge needed.
- **Single transfer**: `Req`=4'b0100, node 2 data 4'hA → `Grant`=4'b0100 at k, `BusData`=4'hA with `BusValid` pulse at k+2, `Grant`=0 at k+5.
- **Fairness**: `Req`=4'b1111 held, distinct data 1,2,3,4 → owners in order 0,1,2,3,0 and `BusData` sequence 1,2,3,4,1.
- **Abort**: node 1 drops `Req` during GRANT → no `BusValid`, `BusData` unchanged; the next round still gives node 1 priority.
- **HOLD_CYCLES=0**: back-to-back requests → transfers every 3 cycles.
- **MDB_PARITY_EN**: node 3 sends 4'h7 with wrong parity → `ParErr` pulse, `BusData` retains the previous value.

Source files
------------

// File: rtl/mdb_pkg.sv
// Shared definitions for the multi-drop bus arbiter: FSM state codes, default sizes and a clog2 helper.
// No logic and no latency; the package is imported by the picker and the top level.
package mdb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int MDB_NUM_NODES_DEF = 4;
    localparam int MDB_DATA_W_DEF    = 4;

    // Never returns less than 1, so single-value ranges still get a real bit.
    function automatic int mdb_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mdb_rr_picker.sv
// Round-robin selector: picks the first requester, searching upward from Ptr+1 and wrapping around.
// Purely combinational with zero latency and no backpressure; AnyReq qualifies Winner.
module mdb_rr_picker
    import mdb_pkg::*;
#(
    parameter int NUM_NODES = MDB_NUM_NODES_DEF,
    parameter int IDX_W     = mdb_clog2(NUM_NODES)
) (
    input  logic [NUM_NODES-1:0] Req,
    input  logic [IDX_W-1:0]     Ptr,
    output logic [IDX_W-1:0]     Winner,
    output logic                 AnyReq
);

    int   idx;
    logic found;

    // Ptr itself is visited last, so the node that owned the bus most recently has the lowest priority.
    always_comb begin
        Winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_NODES; i++) begin
            idx = (int'(Ptr) + i) % NUM_NODES;
            if (!found && Req[idx]) begin
                Winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign AnyReq = |Req;

endmodule

// File: rtl/mdb_bus_arbiter.sv
// Multi-drop bus arbiter: round-robin grant, nibble capture into a held bus register (optional MDB_PARITY_EN check).
// Latency: Grant one edge after Req, BusData/BusValid two edges after Grant, then HOLD_CYCLES of hold.
// Backpressure: none; Req is a level, nodes wait in IDLE arbitration and Req changes during HOLD are ignored.
module mdb_bus_arbiter
    import mdb_pkg::*;
#(
    parameter  int NUM_NODES   = MDB_NUM_NODES_DEF,
    parameter  int DATA_W      = MDB_DATA_W_DEF,
    parameter  int HOLD_CYCLES = 3,
    localparam int IDX_W       = mdb_clog2(NUM_NODES)
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [NUM_NODES-1:0]        Req,
    input  logic [NUM_NODES*DATA_W-1:0] NodeData,
`ifdef MDB_PARITY_EN
    input  logic [NUM_NODES-1:0]        NodePar,
    output logic                        ParErr,
`endif
    output logic [NUM_NODES-1:0]        Grant,
    output logic [IDX_W-1:0]            Owner,
    output logic [DATA_W-1:0]           BusData,
    output logic                        BusValid
);

    localparam int CNT_W = mdb_clog2(HOLD_CYCLES + 1);
    // The counter holds the number of HOLD cycles still to come after the current one.
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    logic [1:0]           state_q,     state_d;
    logic [NUM_NODES-1:0] grant_q,     grant_d;
    logic [IDX_W-1:0]     owner_q,     owner_d;
    logic [IDX_W-1:0]     ptr_q,       ptr_d;
    logic [DATA_W-1:0]    bus_data_q,  bus_data_d;
    logic                 bus_valid_q, bus_valid_d;
    logic [CNT_W-1:0]     hold_cnt_q,  hold_cnt_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [DATA_W-1:0]    sel_dat;
    logic                 owner_req;
    logic                 cap_ok;

    mdb_rr_picker #(
        .NUM_NODES (NUM_NODES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .Req    (Req),
        .Ptr    (ptr_q),
        .Winner (pick_idx),
        .AnyReq (pick_any)
    );

    always_comb begin
        sel_dat   = '0;
        owner_req = 1'b0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (owner_q == IDX_W'(i)) begin
                sel_dat   = NodeData[i*DATA_W +: DATA_W];
                owner_req = Req[i];
            end
        end
    end

`ifdef MDB_PARITY_EN
    logic sel_par;
    logic par_err_q, par_err_d;

    always_comb begin
        sel_par = 1'b0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (owner_q == IDX_W'(i)) begin
                sel_par = NodePar[i];
            end
        end
    end

    // Even parity: the parity bit makes the total count of ones in nibble plus parity even.
    assign cap_ok = ((^sel_dat) == sel_par);
`else
    assign cap_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        bus_data_d  = bus_data_q;
        bus_valid_d = 1'b0;
        hold_cnt_d  = hold_cnt_q;
`ifdef MDB_PARITY_EN
        par_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = NUM_NODES'(1) << pick_idx;
                    owner_d = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A dropped request aborts without touching Ptr, so the node keeps its priority.
                if (owner_req) begin
                    state_d = ST_XFER;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                ptr_d = owner_q;
                if (cap_ok) begin
                    bus_data_d  = sel_dat;
                    bus_valid_d = 1'b1;
                end else begin
`ifdef MDB_PARITY_EN
                    par_err_d   = 1'b1;
`endif
                end
                if (HOLD_CYCLES == 0) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            ptr_q       <= IDX_W'(NUM_NODES - 1);
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            bus_data_q  <= bus_data_d;
            bus_valid_q <= bus_valid_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

`ifdef MDB_PARITY_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign ParErr = par_err_q;

    a_valid_vs_parerr: assert property (@(posedge Clk) disable iff (!Rst_n) !(bus_valid_q && par_err_q));
`endif

    assign Grant    = grant_q;
    assign Owner    = owner_q;
    assign BusData  = bus_data_q;
    assign BusValid = bus_valid_q;

    a_grant_onehot0: assert property (@(posedge Clk) disable iff (!Rst_n) $onehot0(grant_q));
    a_valid_pulse:   assert property (@(posedge Clk) disable iff (!Rst_n) bus_valid_q |=> !bus_valid_q);

endmodule

// File: tb/tb_mdb_bus_arbiter.sv
// Bench for mdb_bus_arbiter: a HOLD_CYCLES=3 instance under a transfer scoreboard plus a HOLD_CYCLES=0 instance.
// Parity scenarios are exercised when MDB_PARITY_EN is defined.
module tb_mdb_bus_arbiter;

    typedef struct {
        logic [1:0] own;
        logic [3:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] node_data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [3:0]  bus_data;
    logic        bus_valid;

    logic [3:0]  req0;
    logic [3:0]  grant0;
    logic [1:0]  owner0;
    logic [3:0]  bus_data0;
    logic        bus_valid0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t mon_e;

`ifdef MDB_PARITY_EN
    logic [3:0] par_flip;
    logic [3:0] node_par;
    logic [3:0] node_par0;
    logic       par_err;
    logic       par_err0;

    function automatic logic [3:0] good_par(input logic [15:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^d[i*4 +: 4];
        return p;
    endfunction

    assign node_par  = good_par(node_data) ^ par_flip;
    assign node_par0 = good_par(node_data);
`endif

    mdb_bus_arbiter #(.NUM_NODES(4), .DATA_W(4), .HOLD_CYCLES(3)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .Req      (req),
        .NodeData (node_data),
`ifdef MDB_PARITY_EN
        .NodePar  (node_par),
        .ParErr   (par_err),
`endif
        .Grant    (grant),
        .Owner    (owner),
        .BusData  (bus_data),
        .BusValid (bus_valid)
    );

    mdb_bus_arbiter #(.NUM_NODES(4), .DATA_W(4), .HOLD_CYCLES(0)) dut0 (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .Req      (req0),
        .NodeData (node_data),
`ifdef MDB_PARITY_EN
        .NodePar  (node_par0),
        .ParErr   (par_err0),
`endif
        .Grant    (grant0),
        .Owner    (owner0),
        .BusData  (bus_data0),
        .BusValid (bus_valid0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every transfer seen on the main instance must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: BusValid=1 owner=%0d data=%h, required no transfer", owner, bus_data);
            end else begin
                mon_e = sb.pop_front();
                if (owner !== mon_e.own || bus_data !== mon_e.dat) begin
                    errors++;
                    $display("FAIL sb_transfer: owner=%0d data=%h, required owner=%0d data=%h",
                             owner, bus_data, mon_e.own, mon_e.dat);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_grant_set(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (grant !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_grant_clear(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (grant === 4'b0000) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        req0      = 4'b0000;
        node_data = 16'h4321;
`ifdef MDB_PARITY_EN
        par_flip  = 4'b0000;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        req0      = 4'b0000;
        node_data = 16'h4321;
`ifdef MDB_PARITY_EN
        par_flip  = 4'b0000;
`endif
        @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || owner !== 2'd0 || bus_data !== 4'h0 || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b owner=%0d data=%h valid=%b, required 0000/0/0/0",
                     grant, owner, bus_data, bus_valid);
        end
        checks++;
        if (grant0 !== 4'b0000 || bus_data0 !== 4'h0 || bus_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_h0: grant=%b data=%h valid=%b, required 0000/0/0", grant0, bus_data0, bus_valid0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        node_data = 16'h3A21;
        req       = 4'b0100;
        sb.push_back('{own: 2'd2, dat: 4'hA});
        tick();
        checks++;
        if (grant !== 4'b0100 || owner !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: grant=%b owner=%0d, required 0100/2", grant, owner);
        end
        tick();
        checks++;
        if (grant !== 4'b0100 || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_xfer_phase: grant=%b valid=%b, required 0100/0", grant, bus_valid);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (bus_valid !== 1'b1 || bus_data !== 4'hA) begin
            errors++;
            $display("FAIL single_capture: valid=%b data=%h, required 1/a", bus_valid, bus_data);
        end
        tick();
        tick();
        checks++;
        if (grant !== 4'b0100 || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: grant=%b valid=%b, required 0100/0", grant, bus_valid);
        end
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: grant=%b, required 0000 at k+5", grant);
        end
        repeat (3) tick();
        checks++;
        if (bus_data !== 4'hA || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_held: data=%h valid=%b, required a/0", bus_data, bus_valid);
        end
        wait_grant_clear(ok);
    endtask

    task automatic test_fairness();
        bit         ok;
        int         ptr_m;
        int         t_last;
        logic [1:0] exp_own[5];
        logic [3:0] exp_g;
        do_reset();
        ptr_m = 3;
        for (int r = 0; r < 5; r++) begin
            ptr_m      = (ptr_m + 1) % 4;
            exp_own[r] = 2'(ptr_m);
            sb.push_back('{own: 2'(ptr_m), dat: 4'(ptr_m + 1)});
        end
        node_data = 16'h4321;
        req       = 4'b1111;
        t_last    = 0;
        for (int r = 0; r < 5; r++) begin
            wait_grant_set(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL fair_timeout: round %0d grant=%b, required a grant", r, grant);
            end
            exp_g = 4'b0001 << exp_own[r];
            checks++;
            if (owner !== exp_own[r] || grant !== exp_g) begin
                errors++;
                $display("FAIL fair_owner: round %0d owner=%0d grant=%b, required %0d/%b", r, owner, grant, exp_own[r], exp_g);
            end
            if (r > 0) begin
                checks++;
                if (cyc - t_last !== 6) begin
                    errors++;
                    $display("FAIL fair_spacing: round %0d spacing=%0d, required 6", r, cyc - t_last);
                end
            end
            t_last = cyc;
            if (r == 4) begin
                tick();
                req = 4'b0000;
            end
            wait_grant_clear(ok);
        end
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL fair_drain: %0d transfers outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_abort();
        bit ok;
        do_reset();
        node_data = 16'h4321;
        req       = 4'b0001;
        sb.push_back('{own: 2'd0, dat: 4'h1});
        tick();
        tick();
        req = 4'b0000;
        wait_grant_clear(ok);
        tick();
        req = 4'b0110;
        tick();
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL abort_grant: grant=%b owner=%0d, required 0010/1", grant, owner);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL abort_release: grant=%b, required 0000", grant);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus_valid !== 1'b0 || bus_data !== 4'h1) begin
                errors++;
                $display("FAIL abort_no_capture: cycle %0d valid=%b data=%h, required 0/1", i, bus_valid, bus_data);
            end
            tick();
        end
        req = 4'b0110;
        sb.push_back('{own: 2'd1, dat: 4'h2});
        tick();
        checks++;
        if (grant !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL abort_priority: grant=%b owner=%0d, required 0010/1", grant, owner);
        end
        tick();
        req = 4'b0000;
        wait_grant_clear(ok);
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL abort_drain: %0d transfers outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        node_data = 16'h4321;
        req       = 4'b1000;
        sb.push_back('{own: 2'd3, dat: 4'h4});
        tick();
        tick();
        req = 4'b0000;
        tick();
        tick();
        checks++;
        if (grant !== 4'b1000 || bus_data !== 4'h4) begin
            errors++;
            $display("FAIL rst_pre_hold: grant=%b data=%h, required 1000/4", grant, bus_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || bus_data !== 4'h0 || bus_valid !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL rst_async: grant=%b data=%h valid=%b owner=%0d, required 0000/0/0/0",
                     grant, bus_data, bus_valid, owner);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req = 4'b1111;
        sb.push_back('{own: 2'd0, dat: 4'h1});
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL rst_first_priority: grant=%b, required 0001", grant);
        end
        tick();
        req = 4'b0000;
        wait_grant_clear(ok);
        repeat (2) tick();
    endtask

    task automatic test_back_to_back_hold0();
        int         ptr_m;
        int         pulses;
        int         t_last;
        logic [1:0] exp_o;
        do_reset();
        node_data = 16'h4321;
        req0      = 4'b1111;
        ptr_m     = 3;
        pulses    = 0;
        t_last    = 0;
        for (int i = 0; i < 40 && pulses < 5; i++) begin
            tick();
            if (bus_valid0 === 1'b1) begin
                ptr_m = (ptr_m + 1) % 4;
                exp_o = 2'(ptr_m);
                checks++;
                if (owner0 !== exp_o || bus_data0 !== 4'(ptr_m + 1)) begin
                    errors++;
                    $display("FAIL h0_transfer: pulse %0d owner=%0d data=%h, required %0d/%h",
                             pulses, owner0, bus_data0, exp_o, 4'(ptr_m + 1));
                end
                if (pulses > 0) begin
                    checks++;
                    if (cyc - t_last !== 3) begin
                        errors++;
                        $display("FAIL h0_spacing: pulse %0d spacing=%0d, required 3", pulses, cyc - t_last);
                    end
                end
                t_last = cyc;
                pulses++;
            end
        end
        req0 = 4'b0000;
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL h0_count: %0d transfers seen, required 5", pulses);
        end
        repeat (4) tick();
    endtask

`ifdef MDB_PARITY_EN
    task automatic test_parity();
        bit ok;
        do_reset();
        node_data = 16'h7321;
        req       = 4'b0001;
        sb.push_back('{own: 2'd0, dat: 4'h1});
        tick();
        tick();
        req = 4'b0000;
        wait_grant_clear(ok);
        tick();
        par_flip = 4'b1000;
        req      = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL par_grant: grant=%b, required 1000", grant);
        end
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if (par_err !== 1'b1 || bus_valid !== 1'b0 || bus_data !== 4'h1) begin
            errors++;
            $display("FAIL par_detect: parerr=%b valid=%b data=%h, required 1/0/1", par_err, bus_valid, bus_data);
        end
        tick();
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL par_pulse: parerr=%b, required 0", par_err);
        end
        wait_grant_clear(ok);
        tick();
        par_flip = 4'b0000;
        req      = 4'b1001;
        sb.push_back('{own: 2'd0, dat: 4'h1});
        tick();
        checks++;
        if (owner !== 2'd0) begin
            errors++;
            $display("FAIL par_ptr_advance: owner=%0d, required 0", owner);
        end
        tick();
        req = 4'b0000;
        wait_grant_clear(ok);
        repeat (2) tick();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        req0      = 4'b0000;
        node_data = 16'h0000;
`ifdef MDB_PARITY_EN
        par_flip  = 4'b0000;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_abort();
        test_reset_mid_hold();
        test_back_to_back_hold0();
`ifdef MDB_PARITY_EN
        test_parity();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d transfers outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
